// File: rtl/mac_stream_driver.sv
// Operand buffer plus i/k/b stream initiator and o-stream result sink for the MAC.
// Define MAC_DRV_RESULT_CHECK_EN to add the internal result model and mismatch flag.
module mac_stream_driver #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_i,
   input  logic [W-1:0]             wr_k,
   input  logic [W-1:0]             bias,
   input  logic [$clog2(DEPTH):0]   len,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [W-1:0]             result,
   output logic                     mismatch,
   output logic                     new_o,
   output logic                     i_TVALID,
   output logic                     k_TVALID,
   output logic                     b_TVALID,
   input  logic                     i_TREADY,
   input  logic                     k_TREADY,
   input  logic                     b_TREADY,
   output logic [W-1:0]             i_TDATA,
   output logic [W-1:0]             k_TDATA,
   output logic [W-1:0]             b_TDATA,
   input  logic                     o_TVALID,
   input  logic [W-1:0]             o_TDATA,
   output logic                     o_TREADY
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, BIAS, STREAM, DRAIN} state_t;

   state_t         state;
   state_t         state_d;
   logic [W-1:0]   mem_i [DEPTH];
   logic [W-1:0]   mem_k [DEPTH];
   logic [LW-1:0]  ptr;
   logic [LW-1:0]  len_q;
   logic [W-1:0]   bias_q;
   logic           ik_valid;
   logic           b_valid;
   logic           accept;
   logic           ik_hs;
   logic           b_hs;
   logic           ik_last;
   logic           capture;

   assign accept  = (state == IDLE) && start &&
                    (len != '0) && (len <= LW'(DEPTH));
   assign ik_hs   = ik_valid && i_TREADY && k_TREADY;
   assign b_hs    = b_valid && b_TREADY;
   assign ik_last = ik_hs && (ptr == len_q - LW'(1));
   assign capture = (state == DRAIN) && o_TVALID;

   assign i_TVALID = ik_valid;
   assign k_TVALID = ik_valid;
   assign b_TVALID = b_valid;

   // Data is forced to zero when idle so nothing undefined leaks out of the buffer.
   assign i_TDATA = ik_valid ? mem_i[ptr[AW-1:0]] : '0;
   assign k_TDATA = ik_valid ? mem_k[ptr[AW-1:0]] : '0;
   assign b_TDATA = b_valid ? bias_q : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   // Elements may complete during BIAS while the bias beat is still pending.
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (accept) state_d = BIAS;
         BIAS:    if (b_hs) state_d = (ik_last || !ik_valid) ? DRAIN : STREAM;
         STREAM:  if (ik_last) state_d = DRAIN;
         DRAIN:   if (o_TVALID) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         new_o    <= 1'b0;
         o_TREADY <= 1'b0;
         ik_valid <= 1'b0;
         b_valid  <= 1'b0;
         ptr      <= '0;
         len_q    <= '0;
         bias_q   <= '0;
      end else begin
         busy     <= (state_d != IDLE);
         new_o    <= (state_d == BIAS) || (state_d == STREAM);
         o_TREADY <= (state_d == DRAIN);
         done     <= capture;
         if (capture) result <= o_TDATA;
         if (accept) begin
            len_q    <= len;
            bias_q   <= bias;
            ptr      <= '0;
            ik_valid <= 1'b1;
            b_valid  <= 1'b1;
         end else begin
            if (ik_hs)   ptr      <= ptr + LW'(1);
            if (ik_last) ik_valid <= 1'b0;
            if (b_hs)    b_valid  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && (state == IDLE) && !accept) begin
         mem_i[wr_addr] <= wr_i;
         mem_k[wr_addr] <= wr_k;
      end
   end

`ifdef MAC_DRV_RESULT_CHECK_EN
   logic [W-1:0] acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc      <= '0;
         mismatch <= 1'b0;
      end else if (accept) begin
         acc      <= bias;
         mismatch <= 1'b0;
      end else begin
         if (ik_hs)   acc      <= acc + i_TDATA * k_TDATA;
         if (capture) mismatch <= (o_TDATA != acc);
      end
   end
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mac_stream_driver.sv
// Self-checking bench for mac_stream_driver: directed table plus random runs
// against a dot-product reference model; the bench also plays the MAC.
module tb_mac_stream_driver;

   localparam int DEPTH = 8;
   localparam int W     = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         wr_en = 1'b0;
   logic [2:0]   wr_addr = '0;
   logic [7:0]   wr_i = '0;
   logic [7:0]   wr_k = '0;
   logic [7:0]   bias_in = '0;
   logic [3:0]   len_in = '0;
   logic         start = 1'b0;
   logic         busy, done, mismatch, new_o;
   logic [7:0]   result;
   logic         i_TVALID, k_TVALID, b_TVALID;
   logic         i_TREADY = 1'b1, k_TREADY = 1'b1, b_TREADY = 1'b1;
   logic [7:0]   i_TDATA, k_TDATA, b_TDATA;
   logic         o_TVALID = 1'b0;
   logic [7:0]   o_TDATA = '0;
   logic         o_TREADY;

   mac_stream_driver #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_i(wr_i), .wr_k(wr_k),
      .bias(bias_in), .len(len_in), .start(start),
      .busy(busy), .done(done), .result(result), .mismatch(mismatch),
      .new_o(new_o),
      .i_TVALID(i_TVALID), .k_TVALID(k_TVALID), .b_TVALID(b_TVALID),
      .i_TREADY(i_TREADY), .k_TREADY(k_TREADY), .b_TREADY(b_TREADY),
      .i_TDATA(i_TDATA), .k_TDATA(k_TDATA), .b_TDATA(b_TDATA),
      .o_TVALID(o_TVALID), .o_TDATA(o_TDATA), .o_TREADY(o_TREADY)
   );

   always #5 clk = ~clk;

   typedef struct {
      int             len;
      logic [7:0]     bias;
      logic [7:0][7:0] iv;
      logic [7:0][7:0] kv;
      int             mode;
      int             odelay;
      logic [7:0]     exp;
      bit             disturb;
   } vec_t;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [7:0]  ref_i [8];
   logic [7:0]  ref_k [8];
   logic [7:0]  rcv_i [$];
   logic [7:0]  rcv_k [$];
   logic [7:0]  rcv_b [$];
   int          done_cnt = 0;
   vec_t        tbl [4];
   vec_t        rv;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] ref_result(input vec_t v);
      int s;
      s = int'(v.bias);
      for (int e = 0; e < v.len; e++) s += int'(v.iv[e]) * int'(v.kv[e]);
      return 8'(s % 256);
   endfunction

   // Observes handshakes at the falling edge; inputs only change just after rising edges.
   initial begin
      logic       stall_ik, stall_b;
      logic [7:0] pi, pk, pb;
      stall_ik = 1'b0;
      stall_b  = 1'b0;
      pi = '0; pk = '0; pb = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_ik = 1'b0;
            stall_b  = 1'b0;
         end else begin
            if (done) done_cnt++;
            if (stall_ik)
               chk("ik_hold", {i_TVALID, k_TVALID, i_TDATA, k_TDATA},
                   {2'b11, pi, pk});
            if (stall_b)
               chk("b_hold", {b_TVALID, b_TDATA}, {1'b1, pb});
            if (i_TVALID && i_TREADY && k_TREADY) begin
               rcv_i.push_back(i_TDATA);
               rcv_k.push_back(k_TDATA);
            end
            if (b_TVALID && b_TREADY) rcv_b.push_back(b_TDATA);
            stall_ik = i_TVALID && !(i_TREADY && k_TREADY);
            stall_b  = b_TVALID && !b_TREADY;
            pi = i_TDATA; pk = k_TDATA; pb = b_TDATA;
         end
      end
   end

   task automatic load(input vec_t v);
      for (int e = 0; e < v.len; e++) begin
         wr_en = 1'b1;
         wr_addr = 3'(e);
         wr_i = v.iv[e];
         wr_k = v.kv[e];
         ref_i[e] = v.iv[e];
         ref_k[e] = v.kv[e];
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
   endtask

   task automatic do_run(input vec_t v);
      int         cyc;
      int         newo_cyc;
      int         s;
      rcv_i.delete(); rcv_k.delete(); rcv_b.delete();
      done_cnt = 0;
      start = 1'b1;
      len_in = 4'(v.len);
      bias_in = v.bias;
      i_TREADY = 1'b1; k_TREADY = 1'b1; b_TREADY = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("cycle1_flags", {busy, new_o, i_TVALID, k_TVALID, b_TVALID}, 5'h1f);
      chk("cycle1_data", {b_TDATA, i_TDATA, k_TDATA},
          {v.bias, ref_i[0], ref_k[0]});
      cyc = 0;
      newo_cyc = 0;
      while (!o_TREADY && cyc < 200) begin
         case (v.mode)
            1: begin
               i_TREADY = 1'($urandom % 2);
               k_TREADY = 1'($urandom % 2);
               b_TREADY = 1'($urandom % 2);
            end
            2: begin
               i_TREADY = !(cyc >= 1 && cyc <= 3);
               k_TREADY = 1'b1;
               b_TREADY = 1'b1;
            end
            default: begin
               i_TREADY = 1'b1; k_TREADY = 1'b1; b_TREADY = 1'b1;
            end
         endcase
         start = v.disturb && cyc == 1;
         len_in = 4'd2;
         wr_en = v.disturb && cyc == 1;
         wr_addr = 3'd0; wr_i = 8'hee; wr_k = 8'hee;
         if (new_o) newo_cyc++;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      wr_en = 1'b0;
      if (cyc >= 200) chk("drain_timeout", 1'b0, 1'b1);
      chk("drain_entry", {new_o, i_TVALID, b_TVALID, o_TREADY, busy}, 5'b00011);
      if (v.mode == 0) chk("new_o_cycles", 64'(newo_cyc), 64'(v.len));
      i_TREADY = 1'b0; k_TREADY = 1'b0; b_TREADY = 1'b0;
      for (int d = 0; d < v.odelay; d++) begin
         chk("drain_wait", {o_TREADY, busy, done}, 3'b110);
         @(posedge clk); #1;
      end
      s = 0;
      foreach (rcv_b[j]) s += int'(rcv_b[j]);
      foreach (rcv_i[j]) s += int'(rcv_i[j]) * int'(rcv_k[j]);
      o_TVALID = 1'b1;
      o_TDATA = 8'(s % 256);
      @(posedge clk); #1;
      o_TVALID = 1'b0;
      o_TDATA = 8'($urandom);
      chk("done_pulse", {done, busy, o_TREADY}, 3'b100);
      chk("result", result, v.exp);
      chk("mismatch", mismatch, 1'b0);
      @(posedge clk); #1;
      chk("result_hold", {done, result}, {1'b0, v.exp});
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("beats", {32'(rcv_i.size()), 32'(rcv_b.size())},
          {32'(v.len), 32'd1});
      foreach (rcv_i[j])
         chk("beat_data", {rcv_i[j], rcv_k[j]}, {ref_i[j], ref_k[j]});
   endtask

   initial begin
      for (int t = 0; t < 4; t++) begin
         tbl[t].len = 3; tbl[t].bias = 8'd10;
         tbl[t].iv = '0; tbl[t].kv = '0;
         tbl[t].iv[0] = 8'd1; tbl[t].iv[1] = 8'd2; tbl[t].iv[2] = 8'd3;
         tbl[t].kv[0] = 8'd4; tbl[t].kv[1] = 8'd5; tbl[t].kv[2] = 8'd6;
         tbl[t].mode = 0; tbl[t].odelay = 0;
         tbl[t].exp = 8'd42; tbl[t].disturb = 1'b0;
      end
      tbl[1].len = 1; tbl[1].bias = 8'd100;
      tbl[1].iv[0] = 8'd200; tbl[1].kv[0] = 8'd2; tbl[1].exp = 8'd244;
      tbl[2].mode = 2;
      tbl[3].odelay = 5; tbl[3].disturb = 1'b1;

      #3;
      chk("reset_state",
          {busy, done, mismatch, new_o, i_TVALID, k_TVALID, b_TVALID, o_TREADY},
          8'h00);
      chk("reset_data", {i_TDATA, k_TDATA, b_TDATA, result}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      foreach (tbl[t]) begin
         load(tbl[t]);
         do_run(tbl[t]);
      end
      // Rerun without reloading: the write issued while busy must have been dropped.
      do_run(tbl[0]);

      start = 1'b1; len_in = 4'd0; bias_in = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
      chk("len0_ignored", {busy, new_o, i_TVALID, b_TVALID}, 4'h0);
      start = 1'b1; len_in = 4'd9;
      @(posedge clk); #1;
      start = 1'b0;
      chk("len9_ignored", {busy, new_o, i_TVALID, b_TVALID}, 4'h0);

      load(tbl[0]);
      start = 1'b1; len_in = 4'd3; bias_in = 8'd10;
      i_TREADY = 1'b1; k_TREADY = 1'b1; b_TREADY = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_stream", {busy, new_o, i_TVALID}, 3'b111);
      reset = 1'b1;
      #1;
      chk("reset_mid_run",
          {busy, done, new_o, i_TVALID, k_TVALID, b_TVALID, o_TREADY}, 7'h00);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      load(tbl[0]);
      do_run(tbl[0]);

      for (int r = 0; r < 12; r++) begin
         rv.len = int'($urandom_range(1, 8));
         rv.bias = 8'($urandom);
         rv.iv = '0; rv.kv = '0;
         for (int e = 0; e < rv.len; e++) begin
            rv.iv[e] = 8'($urandom);
            rv.kv[e] = 8'($urandom);
         end
         rv.mode = 1;
         rv.odelay = int'($urandom_range(0, 3));
         rv.disturb = 1'($urandom % 2);
         rv.exp = ref_result(rv);
         load(rv);
         do_run(rv);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
